gray_sync_to_bin: RTL and testbench
===================================

// Module: gray_sync_to_bin
// PURPOSE
//  Receive side of a Gray-coded pointer/counter crossing. Synchronises a
//  Gray-coded pointer from a foreign clock domain into the local domain and
//  decodes it back to binary. Reports the per-update increment (delta) and
//  flags illegal multi-bit transitions. Used on the read side of async FIFOs
//  and on the sink end of cross-domain event counters.
// PARAMETERS
//  WIDTH        4  pointer width in bits (>=2)
//  SYNC_STAGES  2  synchroniser flop depth (>=2)
// PORTS
//  clk      in   1      local clock
//  rst_n    in   1      async reset, active low
//  gray_in  in   WIDTH  Gray pointer, asynchronous to clk, <=1 bit change per source edge
//  en       in   1      1 = accept new decoded value; 0 = hold outputs (sync chain keeps running)
//  bin_out  out  WIDTH  decoded binary pointer (registered)
//  bin_vld  out  1      1 once first decoded sample is present after reset
//  step     out  1      1-cycle pulse when bin_out changes value
//  delta    out  WIDTH  (bin_new - bin_prev) mod 2^WIDTH, valid while step=1, else 0
//  err      out  1      sticky Gray-violation flag (see CONFIGURATION)
//  err_clr  in   1      clears err; set wins if same cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): sync chain, bin_out, delta = 0; bin_vld, step, err = 0;
//    FSM -> FILL, fill counter = 0. Applies immediately, including mid-update.
//  - Sync chain: SYNC_STAGES flops, clocked every cycle regardless of en.
//    Last stage = g_s. No logic between chain flops.
//  - Decode (combinational on g_s): b[WIDTH-1]=g_s[WIDTH-1]; b[i]=b[i+1]^g_s[i].
//  - FSM FILL: counts cycles after reset release; after SYNC_STAGES cycles loads
//    bin_out<=b, bin_prev<=b, bin_vld<=1, no step, -> RUN. en ignored in FILL.
//  - FSM RUN, en=1: bin_out<=b; if b!=bin_out: step=1, delta=b-bin_out (mod 2^W).
//  - FSM RUN, en=0: bin_out/delta held at current/0; step=0; pending change is
//    taken on first cycle en returns (delta covers full accumulated difference).
//  - Latency: gray_in change -> bin_out update = SYNC_STAGES+1 clk edges (en=1).
//  - Wrap: 2^W-1 -> 0 gives delta=1, step=1; not an error.
//  - bin_vld stays 1 until next reset; no other path clears it.
//  - delta is pure modular subtraction; caller owns interpretation of >1 steps.
// CONFIGURATION
//  GRAY_SYNC_ERR_CHECK_EN defined:
//   - register g_prev (previous g_s); each RUN cycle, if popcount(g_s^g_prev)>1
//     then err<=1 (sticky). Checked irrespective of en. Not checked in FILL.
//   - err_clr=1 clears err next edge unless a violation is detected that cycle.
//  GRAY_SYNC_ERR_CHECK_EN undefined:
//   - no g_prev/compare logic; err tied 0; err_clr ignored.
// TESTING
//  T1 reset: rst_n=0 with gray_in=4'b1010 -> all outputs 0; release -> bin_vld=1
//     and bin_out=4'hC after SYNC_STAGES+1 edges, step=0.
//  T2 count: drive Gray 0..15 one value per 4 clks, en=1 -> bin_out=0..15, each
//     appearing 3 edges after gray_in; step=1, delta=1 per update.
//  T3 wrap: gray_in 4'b1000 (15) -> 4'b0000 -> bin_out 15->0, step=1, delta=1, err=0.
//  T4 en hold: en=0, advance Gray 3->7 over several cycles -> bin_out stays 3;
//     en=1 -> one step, bin_out=7, delta=4.
//  T5 error (macro on): gray_in 4'b0000 -> 4'b0011 -> err=1, stays 1; err_clr=1
//     -> err=0. Macro off: same stimulus -> err stays 0.
//  T6 reset mid-run: rst_n=0 during step pulse -> step, bin_vld, bin_out drop to 0
//     asynchronously; FILL repeats after release.

Source files
------------

// File: rtl/gray_sync_to_bin_if.sv
// rtl/gray_sync_to_bin_if.sv - signal bundle between a Gray pointer source and the receive-side decoder
interface gray_sync_to_bin_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] gray_in;
   logic             en;
   logic             err_clr;
   logic [WIDTH-1:0] bin_out;
   logic             bin_vld;
   logic             step;
   logic [WIDTH-1:0] delta;
   logic             err;

   modport master (
      output gray_in, en, err_clr,
      input  bin_out, bin_vld, step, delta, err
   );

   modport slave (
      input  gray_in, en, err_clr,
      output bin_out, bin_vld, step, delta, err
   );
endinterface

// File: rtl/gray_sync_to_bin.sv
// rtl/gray_sync_to_bin.sv - synchronise a foreign-domain Gray pointer, decode to binary, report delta
// Optional sticky multi-bit-transition detector enabled by GRAY_SYNC_ERR_CHECK_EN.
module gray_sync_to_bin #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   gray_sync_to_bin_if.slave  bus
);
   localparam int CW = $clog2(SYNC_STAGES + 1);

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_fill;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_bin_out;
   logic [WIDTH-1:0] r_delta;
   logic             r_bin_vld;
   logic             r_step;
   logic [WIDTH-1:0] w_gs;
   logic [WIDTH-1:0] w_bin;

   // Plain flop chain; nothing may sit between stages or metastability settling time is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= bus.gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_gs = r_sync[SYNC_STAGES-1];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign w_bin[gi] = ^w_gs[WIDTH-1:gi];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FILL;
         r_fill    <= '0;
         r_bin_out <= '0;
         r_bin_vld <= 1'b0;
         r_step    <= 1'b0;
         r_delta   <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               r_step  <= 1'b0;
               r_delta <= '0;
               if (r_fill == CW'(SYNC_STAGES)) begin
                  r_bin_out <= w_bin;
                  r_bin_vld <= 1'b1;
                  r_state   <= S_RUN;
               end else begin
                  r_fill <= r_fill + CW'(1);
               end
            end
            S_RUN: begin
               // While en is low bin_out is frozen, so the next accepted delta spans the whole gap.
               if (bus.en) begin
                  r_bin_out <= w_bin;
                  r_step    <= (w_bin != r_bin_out);
                  r_delta   <= (w_bin != r_bin_out) ? (w_bin - r_bin_out) : '0;
               end else begin
                  r_step  <= 1'b0;
                  r_delta <= '0;
               end
            end
         endcase
      end
   end

   assign bus.bin_out = r_bin_out;
   assign bus.bin_vld = r_bin_vld;
   assign bus.step    = r_step;
   assign bus.delta   = r_delta;

`ifdef GRAY_SYNC_ERR_CHECK_EN
   logic [WIDTH-1:0] r_gprev;
   logic             r_err;
   logic [WIDTH-1:0] w_gdiff;
   logic             w_viol;

   assign w_gdiff = w_gs ^ r_gprev;
   assign w_viol  = (r_state == S_RUN) && ($countones(w_gdiff) > 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gprev <= '0;
         r_err   <= 1'b0;
      end else begin
         r_gprev <= w_gs;
         if (w_viol) begin
            r_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bus.err = r_err;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = bus.err_clr;
   assign bus.err          = 1'b0;
`endif
endmodule

// File: tb/tb_gray_sync_to_bin.sv
// tb/tb_gray_sync_to_bin.sv - randomized self-checking bench for gray_sync_to_bin against a delay-history model
module tb_gray_sync_to_bin;
   localparam int WIDTH = 4;
   localparam int SYNC  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   gray_sync_to_bin_if #(.WIDTH(WIDTH)) bus ();

   gray_sync_to_bin #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: output at edge k is derived from the gray_in sampled SYNC edges earlier.
   int               e = 0;
   logic [WIDTH-1:0] hist[$];
   logic [WIDTH-1:0] m_bin   = '0;
   logic [WIDTH-1:0] m_delta = '0;
   logic             m_vld   = 1'b0;
   logic             m_step  = 1'b0;
   logic             m_err   = 1'b0;
   logic [WIDTH-1:0] src;

   wire [2*WIDTH+2:0] w_obs = {bus.bin_out, bus.bin_vld, bus.step, bus.delta, bus.err};
   wire [2*WIDTH+2:0] w_exp = {m_bin, m_vld, m_step, m_delta, m_err};

   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      for (int i = 0; i < WIDTH; i++) b = b ^ (g >> i);
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [WIDTH-1:0] gs;
      logic [WIDTH-1:0] gp;
      logic [WIDTH-1:0] nb;
      if (!rst_n) begin
         e = 0;
         hist.delete();
         m_bin = '0; m_delta = '0; m_vld = 1'b0; m_step = 1'b0; m_err = 1'b0;
      end else begin
         e++;
         if (e == SYNC + 1) begin
            gs = hist[hist.size()-SYNC];
            m_bin = g2b(gs); m_vld = 1'b1; m_step = 1'b0; m_delta = '0;
         end else if (e > SYNC + 1) begin
            gs = hist[hist.size()-SYNC];
            gp = hist[hist.size()-SYNC-1];
`ifdef GRAY_SYNC_ERR_CHECK_EN
            if ($countones(gs ^ gp) > 1) m_err = 1'b1;
            else if (bus.err_clr) m_err = 1'b0;
`endif
            if (bus.en) begin
               nb      = g2b(gs);
               m_step  = (nb != m_bin);
               m_delta = m_step ? (nb - m_bin) : '0;
               m_bin   = nb;
            end else begin
               m_step  = 1'b0;
               m_delta = '0;
            end
         end
         hist.push_back(bus.gray_in);
         if (hist.size() > SYNC + 2) void'(hist.pop_front());
      end
   end

   task automatic move(input int dir, input int ticks);
      src = src + WIDTH'(dir);
      bus.gray_in = b2g(src);
      repeat (ticks) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.gray_in = 4'b1010; bus.en = 1'b1; bus.err_clr = 1'b0; rst_n = 1'b0;
      src = 4'hC;
      repeat (3) @(negedge clk);
      checks++;
      if (w_obs !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", w_obs); end
      rst_n = 1'b1;
      repeat (SYNC) @(negedge clk);
      checks++;
      if (bus.bin_vld !== 1'b0) begin errors++; $display("FAIL fill_vld_early: got %b want 0", bus.bin_vld); end
      @(negedge clk);
      checks++;
      if ({bus.bin_vld, bus.bin_out, bus.step} !== {1'b1, 4'hC, 1'b0}) begin
         errors++; $display("FAIL fill_load: vld=%b bin=%h step=%b want 1 c 0", bus.bin_vld, bus.bin_out, bus.step);
      end
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL reset_model: got %h want %h", w_obs, w_exp); end
   endtask

   task automatic test_count();
      logic [WIDTH-1:0] vb;
      while (src != '0) move(1, 4);
      for (int v = 1; v < 16; v++) begin
         vb = WIDTH'(v);
         src = vb; bus.gray_in = b2g(vb);
         repeat (SYNC) @(negedge clk);
         checks++;
         if (bus.bin_out !== vb - 1'b1) begin errors++; $display("FAIL count_latency v=%0d: got %h want %h", v, bus.bin_out, vb - 1'b1); end
         @(negedge clk);
         checks++;
         if ({bus.bin_out, bus.step, bus.delta} !== {vb, 1'b1, 4'h1}) begin
            errors++; $display("FAIL count_step v=%0d: bin=%h step=%b delta=%h", v, bus.bin_out, bus.step, bus.delta);
         end
         checks++;
         if (w_obs !== w_exp) begin errors++; $display("FAIL count_model v=%0d: got %h want %h", v, w_obs, w_exp); end
         @(negedge clk);
         checks++;
         if (bus.step !== 1'b0) begin errors++; $display("FAIL count_pulse v=%0d: step=%b want 0", v, bus.step); end
      end
   endtask

   task automatic test_wrap();
      src = '0; bus.gray_in = 4'b0000;
      repeat (SYNC + 1) @(negedge clk);
      checks++;
      if ({bus.bin_out, bus.step, bus.delta, bus.err} !== {4'h0, 1'b1, 4'h1, 1'b0}) begin
         errors++; $display("FAIL wrap: bin=%h step=%b delta=%h err=%b want 0 1 1 0", bus.bin_out, bus.step, bus.delta, bus.err);
      end
      @(negedge clk);
   endtask

   task automatic test_en_hold();
      while (src != 4'h3) move(1, 4);
      bus.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         move(1, 2);
         checks++;
         if ({bus.bin_out, bus.step} !== {4'h3, 1'b0}) begin
            errors++; $display("FAIL en_hold i=%0d: bin=%h step=%b want 3 0", i, bus.bin_out, bus.step);
         end
      end
      repeat (2) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.bin_out, bus.step, bus.delta} !== {4'h7, 1'b1, 4'h4}) begin
         errors++; $display("FAIL en_release: bin=%h step=%b delta=%h want 7 1 4", bus.bin_out, bus.step, bus.delta);
      end
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL en_model: got %h want %h", w_obs, w_exp); end
      @(negedge clk);
      checks++;
      if (bus.step !== 1'b0) begin errors++; $display("FAIL en_pulse: step=%b want 0", bus.step); end
   endtask

   task automatic test_error();
      logic exp_err;
`ifdef GRAY_SYNC_ERR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      while (src != '0) move(-1, 4);
      src = 4'h2; bus.gray_in = 4'b0011;
      repeat (SYNC + 1) @(negedge clk);
      checks++;
      if ({bus.err, bus.bin_out, bus.delta} !== {exp_err, 4'h2, 4'h2}) begin
         errors++; $display("FAIL err_set: err=%b bin=%h delta=%h want %b 2 2", bus.err, bus.bin_out, bus.delta, exp_err);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bus.err !== exp_err) begin errors++; $display("FAIL err_sticky: err=%b want %b", bus.err, exp_err); end
      bus.err_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b want 0", bus.err); end
      src = '0; bus.gray_in = 4'b0000;
      repeat (SYNC + 1) @(negedge clk);
      checks++;
      if (bus.err !== exp_err) begin errors++; $display("FAIL err_set_wins: err=%b want %b", bus.err, exp_err); end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear2: err=%b want 0", bus.err); end
      bus.err_clr = 1'b0;
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40) begin
            src = src + (($urandom_range(0, 3) == 0) ? WIDTH'(-1) : WIDTH'(1));
            bus.gray_in = b2g(src);
         end else if (r < 44) begin
            bus.gray_in = WIDTH'($urandom);
            src = g2b(bus.gray_in);
         end
         bus.en      = ($urandom_range(0, 3) != 0);
         bus.err_clr = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         checks++;
         if (w_obs !== w_exp) begin errors++; $display("FAIL random i=%0d: got %h want %h", i, w_obs, w_exp); end
      end
      bus.en = 1'b1; bus.err_clr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      src = src + WIDTH'(1); bus.gray_in = b2g(src);
      repeat (SYNC) @(negedge clk);
      @(posedge clk); #1;
      checks++;
      if (bus.step !== 1'b1) begin errors++; $display("FAIL mid_step_pre: step=%b want 1", bus.step); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (w_obs !== '0) begin errors++; $display("FAIL mid_async_reset: got %h want 0", w_obs); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SYNC) @(negedge clk);
      checks++;
      if (bus.bin_vld !== 1'b0) begin errors++; $display("FAIL mid_refill_early: vld=%b want 0", bus.bin_vld); end
      @(negedge clk);
      checks++;
      if ({bus.bin_vld, bus.bin_out, bus.step} !== {1'b1, src, 1'b0}) begin
         errors++; $display("FAIL mid_refill: vld=%b bin=%h step=%b want 1 %h 0", bus.bin_vld, bus.bin_out, bus.step, src);
      end
      checks++;
      if (w_obs !== w_exp) begin errors++; $display("FAIL mid_model: got %h want %h", w_obs, w_exp); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_en_hold();
      test_error();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
